// File: rtl/patch_extractor_gen.sv
// Patch extractor: sweeps an image stored in a 128-bit-wide RAM and presents
// K x K patches (zero-padded at the borders) one at a time to a consumer,
// using a valid/ready handshake.
module patch_extractor_gen #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int CHANNELS   = 1,
  parameter int K          = 7,
  parameter int MAX_K      = 7,
  parameter int STRIDE     = 4,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 2,
  parameter int PAD_LEFT   = 1,
  parameter int PAD_RIGHT  = 2,
  parameter int ADDR_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 ram_re,
  output logic [ADDR_W-1:0]                    ram_addr,
  input  logic [31:0]                          ram_dout0,
  input  logic [31:0]                          ram_dout1,
  input  logic [31:0]                          ram_dout2,
  input  logic [31:0]                          ram_dout3,
  input  logic                                 ram_data_valid,
  output logic [MAX_K-1:0][MAX_K-1:0][31:0]    patch_data_out,
  output logic                                 patch_valid,
  input  logic                                 patch_ready,
  output logic [7:0]                           out_row,
  output logic [7:0]                           out_col,
  output logic                                 done
);

  localparam int OUT_W = (IMG_W + PAD_LEFT + PAD_RIGHT - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + PAD_TOP + PAD_BOTTOM - K) / STRIDE + 1;
  localparam int IW    = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  localparam logic [IW-1:0] K_LAST   = IW'(K - 1);
  localparam logic [7:0]    ROW_LAST = 8'(OUT_H - 1);
  localparam logic [7:0]    COL_LAST = 8'(OUT_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CAPT, VALID, DONE} state_t;

  state_t state, state_nx;

  logic [7:0]    pr, pc;
  logic [IW-1:0] ei, ej;
  logic          elem_last, patch_last;

  logic signed [31:0] pix_r, pix_c, byte_s;
  logic [31:0]        byte_u;
  logic               is_pad;

  // Capture pipeline: describes the element issued in the previous cycle
  logic          cap_pend, cap_pad;
  logic [IW-1:0] cap_i, cap_j;
  logic [3:0]    cap_off;

  logic [127:0] rd_word, rd_shift;
  logic [31:0]  cap_elem;

  logic [MAX_K-1:0][MAX_K-1:0][31:0] patch_q;

  assign elem_last      = (ei == K_LAST) && (ej == K_LAST);
  assign patch_last     = (pr == ROW_LAST) && (pc == COL_LAST);
  assign patch_data_out = patch_q;
  assign out_row        = pr;
  assign out_col        = pc;

  // Pixel coordinate of the element being issued, padding test and byte address
  always_comb begin
    pix_r  = $signed({24'd0, pr}) * STRIDE - PAD_TOP  + $signed({{(32-IW){1'b0}}, ei});
    pix_c  = $signed({24'd0, pc}) * STRIDE - PAD_LEFT + $signed({{(32-IW){1'b0}}, ej});
    is_pad = (pix_r < 0) || (pix_r >= IMG_H) || (pix_c < 0) || (pix_c >= IMG_W);
    byte_s = (pix_r * IMG_W + pix_c) * CHANNELS;
    byte_u = $unsigned(byte_s);
  end

  // Assemble the element from the returned word: channel ch comes from word byte off+ch
  always_comb begin
    rd_word  = {ram_dout0, ram_dout1, ram_dout2, ram_dout3};
    rd_shift = '0;
    cap_elem = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      rd_shift = rd_word << (8 * (32'(cap_off) + ch));
      cap_elem[8*ch +: 8] = rd_shift[127:120];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start)     state_nx = LOAD;
      LOAD:       if (elem_last) state_nx = CAPT;
      CAPT:                      state_nx = VALID;
      VALID:      if (patch_ready) state_nx = patch_last ? DONE : LOAD;
      default:                   state_nx = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    ram_re      = (state == LOAD) && !is_pad;
    ram_addr    = ram_re ? ADDR_W'(byte_u >> 4) : '0;
    patch_valid = (state == VALID);
    done        = (state == DONE);
  end

  // Datapath: element/patch counters, read-capture pipeline and patch buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      pr       <= '0;
      pc       <= '0;
      ei       <= '0;
      ej       <= '0;
      cap_pend <= 1'b0;
      cap_pad  <= 1'b0;
      cap_i    <= '0;
      cap_j    <= '0;
      cap_off  <= '0;
      patch_q  <= '0;
    end else begin
      cap_pend <= (state == LOAD);
      cap_pad  <= is_pad;
      cap_i    <= ei;
      cap_j    <= ej;
      cap_off  <= byte_u[3:0];

      // Padding is written unconditionally; real data only when the RAM says so
      if (cap_pend) begin
        if (cap_pad)             patch_q[cap_i][cap_j] <= '0;
        else if (ram_data_valid) patch_q[cap_i][cap_j] <= cap_elem;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            pr      <= '0;
            pc      <= '0;
            ei      <= '0;
            ej      <= '0;
            patch_q <= '0;
          end
        end
        LOAD: begin
          if (ej == K_LAST) begin
            ej <= '0;
            ei <= (ei == K_LAST) ? '0 : ei + 1'b1;
          end else begin
            ej <= ej + 1'b1;
          end
        end
        VALID: begin
          if (patch_ready && !patch_last) begin
            if (pc == COL_LAST) begin
              pc <= '0;
              pr <= pr + 8'd1;
            end else begin
              pc <= pc + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_extractor_gen.sv
// Directed bench for patch_extractor_gen: a default 32x32 instance and a
// 4-channel 8x8 instance, each fed by a 1-cycle-latency RAM model whose image
// byte at byte address b is b & 8'hFF.
module tb_patch_extractor_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, patch_ready, start4, ready4;

  logic        ram_re, ram_dv, done, patch_valid;
  logic [15:0] ram_addr;
  logic [31:0] d0, d1, d2, d3;
  logic [6:0][6:0][31:0] p0;
  logic [7:0]  out_row, out_col;

  logic        ram_re4, ram_dv4, done4, patch_valid4;
  logic [15:0] ram_addr4;
  logic [31:0] e0, e1, e2, e3;
  logic [6:0][6:0][31:0] p4;
  logic [7:0]  out_row4, out_col4;

  int vectors = 0;
  int miscompares = 0;

  patch_extractor_gen u_dut (
    .clk(clk), .reset(reset), .start(start),
    .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_dout0(d0), .ram_dout1(d1), .ram_dout2(d2), .ram_dout3(d3),
    .ram_data_valid(ram_dv), .patch_data_out(p0), .patch_valid(patch_valid),
    .patch_ready(patch_ready), .out_row(out_row), .out_col(out_col), .done(done)
  );

  patch_extractor_gen #(
    .IMG_W(8), .IMG_H(8), .CHANNELS(4), .K(3), .MAX_K(7), .STRIDE(1),
    .PAD_TOP(1), .PAD_BOTTOM(1), .PAD_LEFT(1), .PAD_RIGHT(1), .ADDR_W(16)
  ) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .ram_re(ram_re4), .ram_addr(ram_addr4),
    .ram_dout0(e0), .ram_dout1(e1), .ram_dout2(e2), .ram_dout3(e3),
    .ram_data_valid(ram_dv4), .patch_data_out(p4), .patch_valid(patch_valid4),
    .patch_ready(ready4), .out_row(out_row4), .out_col(out_col4), .done(done4)
  );

  function automatic logic [127:0] word_of(input logic [15:0] a);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[127-8*k -: 8] = 8'(32'(a) * 16 + k);
    return w;
  endfunction

  // RAM models: sample the request mid-cycle, return data just after the edge
  logic        re_s, re4_s;
  logic [15:0] a_s, a4_s;
  always @(negedge clk) begin
    re_s = ram_re;   a_s  = ram_addr;
    re4_s = ram_re4; a4_s = ram_addr4;
  end
  always @(posedge clk) begin
    #1;
    ram_dv  = re_s;
    {d0, d1, d2, d3} = word_of(a_s);
    ram_dv4 = re4_s;
    {e0, e1, e2, e3} = word_of(a4_s);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int reads, n, cyc;
  logic any_nz;

  initial begin
    reset = 1'b1; start = 1'b0; patch_ready = 1'b0; start4 = 1'b0; ready4 = 1'b0;
    re_s = 1'b0; re4_s = 1'b0; a_s = '0; a4_s = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_patch_valid", 32'(patch_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_elem33", p0[3][3], 32'd0);
    reset = 1'b0;
    tick();

    // First patch: issue pattern, read count and latency to patch_valid
    start = 1'b1;
    tick();
    start = 1'b0;
    reads = 0;
    for (int e = 0; e < 49; e++) begin
      int i, j;
      i = e / 7; j = e % 7;
      chk($sformatf("p00_re_e%0d", e), 32'(ram_re), 32'((i > 0) && (j > 0)));
      if (i > 0 && j > 0)
        chk($sformatf("p00_addr_e%0d", e), 32'(ram_addr), 32'(((i - 1) * 32 + (j - 1)) >> 4));
      else
        chk($sformatf("p00_addr_e%0d", e), 32'(ram_addr), 32'd0);
      chk($sformatf("p00_nvalid_e%0d", e), 32'(patch_valid), 32'd0);
      reads += int'(ram_re);
      tick();
    end
    chk("capt_nvalid", 32'(patch_valid), 32'd0);
    tick();
    chk("valid_at_51", 32'(patch_valid), 32'd1);
    chk("p00_reads", 32'(reads), 32'd36);

    // Patch (0,0) content
    for (int j = 0; j < 7; j++) chk($sformatf("p00_row0_%0d", j), p0[0][3'(j)], 32'd0);
    chk("p00_e11", p0[1][1], 32'h00);
    chk("p00_e12", p0[1][2], 32'h01);
    chk("p00_e21", p0[2][1], 32'h20);
    chk("p00_e61", p0[6][1], 32'hA0);
    chk("p00_e66", p0[6][6], 32'hA5);

    // Back-pressure: 20 cycles with patch_ready low
    for (int c = 0; c < 20; c++) begin
      chk("hold_valid", 32'(patch_valid), 32'd1);
      chk("hold_ram_re", 32'(ram_re), 32'd0);
      chk("hold_e12", p0[1][2], 32'h01);
      chk("hold_row", 32'(out_row), 32'd0);
      chk("hold_col", 32'(out_col), 32'd0);
      tick();
    end

    // Full sweep with patch_ready high; start held across patches 2..3 is ignored
    patch_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 5000) begin
      if (patch_valid) begin
        chk($sformatf("sweep_row_%0d", n), 32'(out_row), 32'(n / 8));
        chk($sformatf("sweep_col_%0d", n), 32'(out_col), 32'(n % 8));
        if (n == 9) chk("p11_e00", p0[0][0], 32'h63);
        if (n == 63) begin
          chk("p77_e00", p0[0][0], 32'h7B);
          chk("p77_e44", p0[4][4], 32'hFF);
          chk("p77_e45", p0[4][5], 32'h00);
          chk("p77_e66", p0[6][6], 32'h00);
        end
        n++;
      end
      start = (n >= 2 && n <= 3);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("sweep_patches", 32'(n), 32'd64);
    chk("done_after_last", 32'(done), 32'd1);
    chk("done_nvalid", 32'(patch_valid), 32'd0);
    chk("done_ram_re", 32'(ram_re), 32'd0);
    repeat (3) tick();
    chk("done_holds", 32'(done), 32'd1);

    // Start in DONE restarts at (0,0) with a cleared buffer
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_row", 32'(out_row), 32'd0);
    chk("restart_col", 32'(out_col), 32'd0);
    chk("restart_cleared", p0[6][6], 32'd0);
    repeat (9) tick();

    // Reset at LOAD cycle 10; the in-flight read must not land afterwards
    reset = 1'b1;
    tick();
    chk("mid_rst_re", 32'(ram_re), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_valid", 32'(patch_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_row", 32'(out_row), 32'd0);
    chk("mid_rst_col", 32'(out_col), 32'd0);
    reset = 1'b0;
    tick();
    any_nz = 1'b0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        if (p0[3'(i)][3'(j)] !== 32'd0) any_nz = 1'b1;
    chk("mid_rst_elems_zero", 32'(any_nz), 32'd0);
    chk("mid_rst_idle_re", 32'(ram_re), 32'd0);

    // Fresh start after reset
    patch_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!patch_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("post_rst_valid", 32'(patch_valid), 32'd1);
    chk("post_rst_wait", 32'(cyc), 32'd50);
    chk("post_rst_row", 32'(out_row), 32'd0);
    chk("post_rst_col", 32'(out_col), 32'd0);
    chk("post_rst_e12", p0[1][2], 32'h01);
    chk("post_rst_e00", p0[0][0], 32'h00);

    // Four-channel instance
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 0;
    while (!patch_valid4 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("c4_valid", 32'(patch_valid4), 32'd1);
    chk("c4_e00", p4[0][0], 32'h0);
    chk("c4_e11", p4[1][1], 32'h03020100);
    chk("c4_e12", p4[1][2], 32'h07060504);
    chk("c4_e22", p4[2][2], 32'h27262524);
    chk("c4_e33", p4[3][3], 32'h0);
    chk("c4_e15", p4[1][5], 32'h0);
    ready4 = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 2000) begin
      if (patch_valid4) begin
        chk($sformatf("c4_row_%0d", n), 32'(out_row4), 32'(n / 8));
        chk($sformatf("c4_col_%0d", n), 32'(out_col4), 32'(n % 8));
        if (n == 63) begin
          chk("c4_p77_e11", p4[1][1], 32'hFFFEFDFC);
          chk("c4_p77_e22", p4[2][2], 32'h0);
        end
        n++;
      end
      tick();
      cyc++;
    end
    chk("c4_patches", 32'(n), 32'd64);
    chk("c4_done", 32'(done4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/patch_extractor_gen.md
PATCH_EXTRACTOR_GEN -- requirements
Module: patch_extractor_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 32: image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 32: image height in pixels.
REQ-003 SHALL have parameter CHANNELS, default 1: bytes per pixel; legal values are 1, 2 and 4.
REQ-004 SHALL have parameter K, default 7: patch edge length; legal range is 1..MAX_K.
REQ-005 SHALL have parameter MAX_K, default 7: output array edge length.
REQ-006 SHALL have parameter STRIDE, default 4: step between patches, in pixels.
REQ-007 SHALL have parameters PAD_TOP, PAD_BOTTOM, PAD_LEFT and PAD_RIGHT, defaults 1, 2, 1 and 2: zero border widths.
REQ-008 SHALL have parameter ADDR_W, default 16: width of the RAM word address.
REQ-009 Ports SHALL be as follows. Single clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a full-image sweep
- ram_re  out  1  read strobe
- ram_addr  out  ADDR_W  128-bit word address
- ram_dout0..ram_dout3  in  32 each  read data; ram_dout0 is most significant, byte 0 = bits 127:120
- ram_data_valid  in  1  read data valid
- patch_data_out  out  [MAX_K-1:0][MAX_K-1:0] x 32  patch elements
- patch_valid  out  1  patch available
- patch_ready  in  1  consumer accepts the patch
- out_row, out_col  out  8 each  output-grid index of the current patch
- done  out  1  sweep complete

Function
REQ-010 OUT_W SHALL equal (IMG_W+PAD_LEFT+PAD_RIGHT-K)/STRIDE+1, and OUT_H SHALL be defined the same way from IMG_H, PAD_TOP and PAD_BOTTOM; both use integer division.
REQ-011 Patch (pr,pc) SHALL have its origin at signed image coordinate (pr*STRIDE-PAD_TOP, pc*STRIDE-PAD_LEFT).
- Patches SHALL be visited in raster order: pc increments first, then pr.
REQ-012 Element (i,j) SHALL map to pixel (r,c) = origin + (i,j).
- The pixel is padding if r<0, r>=IMG_H, c<0 or c>=IMG_W.
- Signed intermediates SHALL be wide enough that no origin offset overflows.
REQ-013 For a non-padding element:
- byte index b = (r*IMG_W+c)*CHANNELS;
- ram_addr = b>>4;
- channel ch SHALL be taken from word byte (b[3:0]+ch) and placed in element bits [8ch+7:8ch];
- unused upper bytes SHALL be zero.
REQ-014 A padding element SHALL be written as 32'h0, with ram_re low in its issue cycle.
REQ-015 Elements with i>=K or j>=K SHALL always read as zero.
REQ-016 States SHALL be IDLE, LOAD, CAPT, VALID and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL:
- enter LOAD;
- set pr=pc=0;
- clear every patch element.
REQ-018 LOAD SHALL last exactly K*K cycles and issue one element per cycle in row-major order.
REQ-019 RAM latency is fixed at 1 cycle. Data for an element issued at cycle t SHALL be captured at the edge ending cycle t+1, qualified by ram_data_valid.
- If ram_data_valid=0 when a read is expected, the element SHALL retain its previous value.
REQ-020 After LOAD, the block SHALL stay 1 cycle in CAPT and then enter VALID.
- patch_valid SHALL be 1 only in VALID.
- patch_data_out, out_row and out_col SHALL be stable while patch_valid=1.
REQ-021 In VALID with patch_ready=1 and the patch not the last:
- the block SHALL advance pc, or wrap pc to 0 and increment pr;
- the block SHALL enter LOAD on the next cycle.
REQ-022 In VALID with patch_ready=1 on patch (OUT_H-1, OUT_W-1), the block SHALL enter DONE.
- done SHALL be 1 only in DONE.
REQ-023 With the default parameters, start sampled at edge 0 SHALL produce patch_valid=1 first at cycle 51 (LOAD 1..49, CAPT 50).
REQ-024 start SHALL be ignored in LOAD, CAPT and VALID.
REQ-025 patch_ready SHALL be ignored outside VALID.
REQ-026 ram_re SHALL be 0 outside LOAD.
- ram_addr SHALL be 0 whenever ram_re=0.

Reset
REQ-027 reset=1 SHALL force IDLE from any state, including mid-LOAD, on the next edge.
REQ-028 Reset values SHALL be as follows:
- ram_re=0, ram_addr=0;
- patch_valid=0, done=0;
- out_row=out_col=0;
- all patch elements 0.
REQ-029 reset SHALL take priority over start.
REQ-030 No read issued before a reset SHALL be captured after it.

Verification
REQ-031 Defaults, image byte = (r*32+c)&8'hFF, start, patch_ready held 1 -> 64 patches arrive.
- Patch (0,0) row 0 is all zero.
- Patch (0,0) element (1,1) = 8'h00 and element (1,2) = 8'h01.
- done is asserted after patch (7,7).
REQ-032 Defaults, patch (0,0) -> ram_re=0 for all of row 0 and column 0 (13 cycles), and exactly 36 reads are issued.
REQ-033 CHANNELS=4, IMG_W=IMG_H=8, K=3, STRIDE=1, pads 1/1/1/1 -> OUT_W=OUT_H=8.
- Patch (0,0) element (1,1) = {byte3,byte2,byte1,byte0} of word 0.
REQ-034 patch_ready held 0 for 20 cycles in VALID -> patch_valid stays 1, data and indices are unchanged, and ram_re=0 throughout.
REQ-035 reset asserted at LOAD cycle 10 -> IDLE and all outputs 0 on the next cycle.
- A following start restarts at patch (0,0).
REQ-036 start pulsed during LOAD and VALID -> no effect; start in DONE -> a new sweep begins from patch (0,0).
